// File: rtl/xilly_seek_ram.sv
// rtl/xilly_seek_ram.sv - seekable auto-incrementing RAM behind a Xillybus address/data stream pair
module xilly_seek_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int WRAP   = 0
) (
    input  logic              bus_clk,
    input  logic              srst,
    input  logic              user_r_rden,
    output logic              user_r_empty,
    output logic [DATA_W-1:0] user_r_data,
    output logic              user_r_eof,
    input  logic              user_r_open,
    input  logic              user_w_wren,
    output logic              user_w_full,
    input  logic [DATA_W-1:0] user_w_data,
    input  logic              user_w_open,
    input  logic [ADDR_W-1:0] user_addr,
    input  logic              user_addr_update,
    input  logic [ADDR_W-1:0] app_addr,
    output logic [DATA_W-1:0] app_rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] eff;
    logic              at_end;
    logic              r_open_d;
    logic              w_open_d;
    logic              blk;
    logic              rd_en;
    logic              wr_en;
    logic              access;
    logic              open_rise;
    logic              eff_last;
    logic              flag;

    always_comb begin
        eff       = user_addr_update ? user_addr : ptr;
        blk       = at_end & ~user_addr_update;
        rd_en     = user_r_rden & ~blk;
        wr_en     = user_w_wren & ~blk;
        access    = rd_en | wr_en;
        open_rise = (user_r_open & ~r_open_d) | (user_w_open & ~w_open_d);
        eff_last  = &eff;
    end

    // A seek in the same cycle lifts the end-of-memory block, so the flags drop with it.
    assign flag         = (WRAP != 0) ? 1'b0 : blk;
    assign user_r_empty = flag;
    assign user_w_full  = flag;
    assign user_r_eof   = flag;

    always_ff @(posedge bus_clk) begin
        if (srst) begin
            ptr      <= '0;
            at_end   <= 1'b0;
            r_open_d <= 1'b0;
            w_open_d <= 1'b0;
        end else begin
            r_open_d <= user_r_open;
            w_open_d <= user_w_open;
            if (open_rise) begin
                ptr    <= '0;
                at_end <= 1'b0;
            end else if (access) begin
                if (!eff_last) begin
                    ptr    <= eff + ADDR_W'(1);
                    at_end <= 1'b0;
                end else if (WRAP != 0) begin
                    ptr    <= '0;
                    at_end <= 1'b0;
                end else begin
                    ptr    <= eff;
                    at_end <= 1'b1;
                end
            end else if (user_addr_update) begin
                ptr    <= user_addr;
                at_end <= 1'b0;
            end
        end
    end

    // The array itself is never reset, so a write strobed during srst still lands.
    always_ff @(posedge bus_clk) begin
        if (wr_en) begin
            mem[eff] <= user_w_data;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (srst) begin
            user_r_data <= '0;
            app_rd_data <= '0;
        end else begin
            if (rd_en) begin
                user_r_data <= mem[eff];
            end
            app_rd_data <= mem[app_addr];
        end
    end

endmodule

// File: tb/tb_xilly_seek_ram.sv
// tb/tb_xilly_seek_ram.sv - self-checking bench for xilly_seek_ram over four parameter sets
module tb_xilly_seek_ram;

    logic        bus_clk = 1'b0;
    logic        srst = 1'b0;
    logic        rden = 1'b0;
    logic        wren = 1'b0;
    logic        upd = 1'b0;
    logic        ropen = 1'b0;
    logic        wopen = 1'b0;
    logic [31:0] wdata = '0;
    logic [8:0]  addr = '0;
    logic [8:0]  aaddr = '0;

    logic [7:0]  rd0, ad0, rd1, ad1;
    logic [31:0] rd2, ad2, rd3, ad3;
    logic [3:0]  emp, ful, eof;

    int unsigned aw  [4] = '{5, 5, 9, 9};
    int unsigned dw  [4] = '{8, 8, 32, 32};
    bit          wrp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    logic [31:0] mm   [4][512];
    bit          kn   [4][512];
    int unsigned mptr [4];
    bit          mend [4];
    bit          mrod [4];
    bit          mwod [4];
    logic [31:0] mrd  [4];
    logic [31:0] mad  [4];
    bit          rv   [4];
    bit          av   [4];

    int checks = 0;
    int failures = 0;

    always #5 bus_clk = ~bus_clk;

    xilly_seek_ram #(.DATA_W(8), .ADDR_W(5), .WRAP(0)) u0 (
        .bus_clk(bus_clk), .srst(srst), .user_r_rden(rden), .user_r_empty(emp[0]),
        .user_r_data(rd0), .user_r_eof(eof[0]), .user_r_open(ropen), .user_w_wren(wren),
        .user_w_full(ful[0]), .user_w_data(wdata[7:0]), .user_w_open(wopen),
        .user_addr(addr[4:0]), .user_addr_update(upd), .app_addr(aaddr[4:0]), .app_rd_data(ad0));

    xilly_seek_ram #(.DATA_W(8), .ADDR_W(5), .WRAP(1)) u1 (
        .bus_clk(bus_clk), .srst(srst), .user_r_rden(rden), .user_r_empty(emp[1]),
        .user_r_data(rd1), .user_r_eof(eof[1]), .user_r_open(ropen), .user_w_wren(wren),
        .user_w_full(ful[1]), .user_w_data(wdata[7:0]), .user_w_open(wopen),
        .user_addr(addr[4:0]), .user_addr_update(upd), .app_addr(aaddr[4:0]), .app_rd_data(ad1));

    xilly_seek_ram #(.DATA_W(32), .ADDR_W(9), .WRAP(0)) u2 (
        .bus_clk(bus_clk), .srst(srst), .user_r_rden(rden), .user_r_empty(emp[2]),
        .user_r_data(rd2), .user_r_eof(eof[2]), .user_r_open(ropen), .user_w_wren(wren),
        .user_w_full(ful[2]), .user_w_data(wdata), .user_w_open(wopen),
        .user_addr(addr), .user_addr_update(upd), .app_addr(aaddr), .app_rd_data(ad2));

    xilly_seek_ram #(.DATA_W(32), .ADDR_W(9), .WRAP(1)) u3 (
        .bus_clk(bus_clk), .srst(srst), .user_r_rden(rden), .user_r_empty(emp[3]),
        .user_r_data(rd3), .user_r_eof(eof[3]), .user_r_open(ropen), .user_w_wren(wren),
        .user_w_full(ful[3]), .user_w_data(wdata), .user_w_open(wopen),
        .user_addr(addr), .user_addr_update(upd), .app_addr(aaddr), .app_rd_data(ad3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] got_r(input int k);
        case (k)
            0:       return 32'(rd0);
            1:       return 32'(rd1);
            2:       return rd2;
            default: return rd3;
        endcase
    endfunction

    function automatic logic [31:0] got_a(input int k);
        case (k)
            0:       return 32'(ad0);
            1:       return 32'(ad1);
            2:       return ad2;
            default: return ad3;
        endcase
    endfunction

    // Reference: word-addressed array plus pointer, applied once per clock edge.
    function automatic void model_step();
        for (int k = 0; k < 4; k++) begin
            int unsigned last = (1 << aw[k]) - 1;
            logic [31:0] dm = (dw[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw[k]) - 1);
            int unsigned e = upd ? (int'(addr) & last) : mptr[k];
            int unsigned aa = int'(aaddr) & last;
            bit blocked = mend[k] && !upd;
            bit do_rd = rden && !blocked;
            bit do_wr = wren && !blocked;
            bit rise = (ropen && !mrod[k]) || (wopen && !mwod[k]);
            if (srst) begin
                mrd[k] = '0; rv[k] = 1'b1;
                mad[k] = '0; av[k] = 1'b1;
            end else begin
                if (do_rd) begin
                    mrd[k] = mm[k][e]; rv[k] = kn[k][e];
                end
                mad[k] = mm[k][aa]; av[k] = kn[k][aa];
            end
            if (do_wr) begin
                mm[k][e] = wdata & dm;
                kn[k][e] = 1'b1;
            end
            if (srst || rise) begin
                mptr[k] = 0; mend[k] = 1'b0;
            end else if (do_rd || do_wr) begin
                if (e < last) begin
                    mptr[k] = e + 1; mend[k] = 1'b0;
                end else if (wrp[k]) begin
                    mptr[k] = 0;
                end else begin
                    mptr[k] = last; mend[k] = 1'b1;
                end
            end else if (upd) begin
                mptr[k] = int'(addr) & last; mend[k] = 1'b0;
            end
            mrod[k] = srst ? 1'b0 : ropen;
            mwod[k] = srst ? 1'b0 : wopen;
        end
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] fl = (wrp[k] || !mend[k]) ? 32'd0 : 32'd1;
            if (rv[k]) check($sformatf("rdata%0d", k), got_r(k), mrd[k]);
            if (av[k]) check($sformatf("app%0d", k), got_a(k), mad[k]);
            check($sformatf("empty%0d", k), 32'(emp[k]), fl);
            check($sformatf("full%0d", k), 32'(ful[k]), fl);
            check($sformatf("eof%0d", k), 32'(eof[k]), fl);
        end
    endtask

    task automatic cyc(input bit rd, input bit wr, input bit up, input logic [8:0] a,
                       input logic [31:0] wd, input bit rs);
        rden = rd; wren = wr; upd = up; addr = a; wdata = wd; srst = rs;
        @(posedge bus_clk);
        model_step();
        #1;
        rden = 1'b0; wren = 1'b0; upd = 1'b0; srst = 1'b0;
        @(negedge bus_clk);
        compare_all();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 512; i++) kn[k][i] = 1'b0;
            mptr[k] = 0; mend[k] = 1'b0; mrod[k] = 1'b0; mwod[k] = 1'b0;
            rv[k] = 1'b0; av[k] = 1'b0; mrd[k] = '0; mad[k] = '0;
        end
        @(negedge bus_clk);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);
        check("rst_rdata", got_r(0), 32'd0);
        check("rst_app", got_a(2), 32'd0);

        // Fill 0x00..0x1F then read it back from a seek to 0.
        cyc(0, 1, 1, 0, 0, 0);
        for (int i = 1; i < 32; i++) cyc(0, 1, 0, 0, i, 0);
        cyc(1, 0, 1, 0, 0, 0);
        check("seq_rd0", got_r(0), 32'h00);
        for (int i = 1; i < 32; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            check("seq_rd", got_r(0), 32'(i));
        end
        check("eof_end", 32'(eof[0]), 32'd1);
        check("empty_end", 32'(emp[0]), 32'd1);
        check("eof_wrap", 32'(eof[1]), 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        check("rd33_hold", got_r(0), 32'h1F);

        // Wrap-around write of three words from address 30.
        cyc(0, 1, 1, 30, 32'hA1, 0);
        check("full_w1", 32'(ful[1]), 32'd0);
        cyc(0, 1, 0, 0, 32'hB2, 0);
        check("full_w2", 32'(ful[1]), 32'd0);
        cyc(0, 1, 0, 0, 32'hC3, 0);
        check("full_w3", 32'(ful[1]), 32'd0);
        aaddr = 30; cyc(0, 0, 0, 0, 0, 0);
        check("wrap_30", got_a(1), 32'hA1);
        aaddr = 31; cyc(0, 0, 0, 0, 0, 0);
        check("wrap_31", got_a(1), 32'hB2);
        aaddr = 0;  cyc(0, 0, 0, 0, 0, 0);
        check("wrap_0", got_a(1), 32'hC3);
        cyc(1, 0, 0, 0, 0, 0);
        check("wrap_ptr1", got_r(1), 32'd1);

        // Seek plus read while stopped at the end.
        check("end_before_seek", 32'(eof[0]), 32'd1);
        cyc(1, 0, 1, 7, 0, 0);
        check("seek_rd7", got_r(0), 32'd7);
        check("seek_eof_clr", 32'(eof[0]), 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        check("seek_ptr8", got_r(0), 32'd8);

        // Same-cycle read and write of one word.
        cyc(0, 1, 1, 4, 32'h55, 0);
        cyc(1, 1, 1, 4, 32'hAA, 0);
        check("rw_old", got_r(0), 32'h55);
        aaddr = 4; cyc(0, 0, 0, 0, 0, 0);
        check("rw_new", got_a(0), 32'hAA);
        cyc(1, 0, 0, 0, 0, 0);
        check("rw_ptr5", got_r(0), 32'd5);

        // Open edge rewinds; reset clears pointer but keeps contents.
        cyc(0, 0, 1, 12, 0, 0);
        wopen = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 32'h3C, 0);
        aaddr = 0; cyc(0, 0, 0, 0, 0, 0);
        check("open_wr0", got_a(0), 32'h3C);
        cyc(0, 0, 1, 20, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        check("srst_rdata", got_r(0), 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        check("srst_keep", got_r(0), 32'h3C);
        wopen = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            logic [8:0] a;
            if ($urandom_range(29) == 0) ropen = ~ropen;
            if ($urandom_range(29) == 0) wopen = ~wopen;
            aaddr = 9'($urandom);
            a = ($urandom_range(2) == 0) ? 9'(511 - $urandom_range(1)) : 9'($urandom);
            cyc(1'($urandom), 1'($urandom), $urandom_range(4) == 0, a, $urandom,
                $urandom_range(199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xilly_seek_ram.md
# xilly_seek_ram

Parametrised, auto-incrementing seekable RAM behind a Xillybus address/data stream pair (user_r_*/user_w_*/user_addr*). It replaces the fixed 8-bit × 32 demo RAM with configurable data width and depth, and adds:
- a shared address pointer that advances on every access;
- end-of-memory signalling (EOF/full) or wrap-around;
- pointer rewind on file open;
- a read-only application port so user logic can read the contents.

It sits in the top level, directly on the xillybus core's bus_clk domain.

## Interface
Parameters:
- DATA_W, default 8: word width of the stream and the RAM.
- ADDR_W, default 5: address width. DEPTH = 2^ADDR_W.
- WRAP, default 0. 0: the pointer stops at the end of memory and signals EOF/full. 1: the pointer wraps from DEPTH-1 to 0 and never signals EOF/full.

Ports:
- bus_clk  in  1  sole clock; everything is sampled on the rising edge.
- srst  in  1  synchronous, active-high reset.
- user_r_rden  in  1  read strobe from the core.
- user_r_empty  out  1  no more data is readable.
- user_r_data  out  DATA_W  read data, registered.
- user_r_eof  out  1  end of file.
- user_r_open  in  1  read file is open.
- user_w_wren  in  1  write strobe from the core.
- user_w_full  out  1  the write is refused.
- user_w_data  in  DATA_W  write data.
- user_w_open  in  1  write file is open.
- user_addr  in  ADDR_W  seek address.
- user_addr_update  in  1  seek strobe; loads user_addr.
- app_addr  in  ADDR_W  application read address.
- app_rd_data  out  DATA_W  application read data, registered.

## Operation
State:
- ptr[ADDR_W]: shared read/write pointer.
- at_end: set when the pointer has stopped at the end (WRAP=0 only).
- r_open_d, w_open_d: registered copies of the open inputs, used for edge detection.
- RAM[DEPTH][DATA_W]: contents are not cleared by srst.

Effective address: eff = user_addr_update ? user_addr : ptr. When a seek coincides with an access, the access uses the new address.

Flags:
- blk = at_end & !user_addr_update
- user_r_empty = user_w_full = user_r_eof = at_end when WRAP=0.
- All three are constant 0 when WRAP=1.

Accesses:
- Write: when user_w_wren & !blk, then RAM[eff] <= user_w_data.
- Read: when user_r_rden & !blk, then user_r_data <= RAM[eff]. The read returns the pre-write contents when it coincides with a write to the same word.
- If either strobe arrives while blk is set, it is ignored: no RAM change, user_r_data holds, no advance.

Pointer update, priority high to low:
1. srst: ptr <= 0, at_end <= 0.
2. Rising edge of user_r_open or user_w_open (input 1, registered copy 0): ptr <= 0, at_end <= 0.
3. An access that is performed (rden or wren, or both in the same cycle, which advances once):
   - if eff < DEPTH-1: ptr <= eff+1, at_end <= 0.
   - if eff == DEPTH-1 and WRAP=1: ptr <= 0.
   - if eff == DEPTH-1 and WRAP=0: ptr <= DEPTH-1, at_end <= 1.
4. user_addr_update alone: ptr <= user_addr, at_end <= 0.
5. Otherwise hold.

Other rules:
- Pointer arithmetic is modulo 2^ADDR_W; no extra carry bit is kept.
- The application port reads every cycle: app_rd_data <= RAM[app_addr]. It is independent of the stream side and returns old data on a same-cycle write to that address.
- srst mid-stream: the pointer and flags clear on the next edge. A write strobed in the reset cycle is still performed at eff, because the RAM is not reset.

## Timing
- Reset values: user_r_data = 0, app_rd_data = 0, user_r_empty/user_w_full/user_r_eof = 0, ptr = 0, at_end = 0, r_open_d = w_open_d = 0.
- Read latency: user_r_data is valid on the edge after the rden edge, which is standard-FIFO behaviour. App port latency is 1 cycle.
- Write: RAM is updated on the wren edge. A read of the same word in the next cycle returns the new data.
- Flags: empty/full/eof rise in the cycle after the access to DEPTH-1. They fall in the cycle after an addr_update or open edge, and they are combinationally masked during the seek cycle itself.
- The pointer is usable for back-to-back accesses: one access per cycle at full rate.

## Test plan
- DATA_W=8, ADDR_W=5, WRAP=0: seek to 0, write 0x00..0x1F on 32 consecutive cycles, then seek to 0 and issue 32 rdens. Required: user_r_data returns 0x00..0x1F, each one cycle after its rden. empty and eof rise after the 32nd read; a 33rd rden leaves data at 0x1F.
- WRAP=1: seek to 30, write A, B, C. Required: RAM[30]=A, RAM[31]=B, RAM[0]=C, ptr=1, and full stays 0 throughout.
- user_addr_update with user_addr=7 in the same cycle as rden, after the pointer has reached the end. Required: data = RAM[7] next cycle, ptr=8, eof cleared.
- wren and rden in the same cycle at eff=4, with RAM[4]=0x55 and write data 0xAA. Required: user_r_data=0x55, RAM[4]=0xAA (checked via app port with app_addr=4, giving 0xAA two cycles later), ptr=5.
- Rising edge of user_w_open with ptr=12 and at_end=0, then a write of 0x3C without a seek. Required: the write lands at RAM[0]. Also assert srst at ptr=20: required ptr=0 and user_r_data=0 next cycle, with RAM contents retained.
- Parameter sweep DATA_W=32, ADDR_W=9: random seeks, reads and writes checked against a reference model, including accesses at eff=511 in both WRAP modes.
